// File: rtl/hex_pkg.sv
// hex_pkg
// Shared definitions for the 7-segment scan controller and its decoder.
//   SEG_BLANK     : active-low segment pattern with every segment off
//   MAX_DIGITS    : widest display the anode helper supports
//   scan_state_e  : scan FSM states (IDLE, LIT, GAP)
//   an_off()      : anode vector with the low 'digits' bits set (all off)
package hex_pkg;

  localparam logic [6:0] SEG_BLANK  = 7'h7F;
  localparam int         MAX_DIGITS = 8;

  typedef enum logic [1:0] {
    IDLE,
    LIT,
    GAP
  } scan_state_e;

  // Anodes are active-low, so "all off" is a run of ones as wide as the
  // display; callers truncate the result to their own digit count.
  function automatic logic [MAX_DIGITS-1:0] an_off(input int digits);
    an_off = '0;
    for (int k = 0; k < MAX_DIGITS; k++) begin
      if (k < digits) an_off[k] = 1'b1;
    end
  endfunction

endpackage

// File: rtl/hex.sv
// hex
// Combinational hex nibble to 7-segment decoder, active-low outputs.
//   hex_i : nibble 0..F
//   seg_o : segments {g,f,e,d,c,b,a}, 0 = segment lit
module hex (
  input  logic [3:0] hex_i,
  output logic [6:0] seg_o
);

  // Plain lookup of the usual 7-segment glyphs, lower-case b and d so that
  // they stay distinguishable from 8 and 0.
  always_comb begin
    seg_o = 7'h7F;
    case (hex_i)
      4'h0: seg_o = 7'b1000000;
      4'h1: seg_o = 7'b1111001;
      4'h2: seg_o = 7'b0100100;
      4'h3: seg_o = 7'b0110000;
      4'h4: seg_o = 7'b0011001;
      4'h5: seg_o = 7'b0010010;
      4'h6: seg_o = 7'b0000010;
      4'h7: seg_o = 7'b1111000;
      4'h8: seg_o = 7'b0000000;
      4'h9: seg_o = 7'b0010000;
      4'hA: seg_o = 7'b0001000;
      4'hB: seg_o = 7'b0000011;
      4'hC: seg_o = 7'b1000110;
      4'hD: seg_o = 7'b0100001;
      4'hE: seg_o = 7'b0000110;
      4'hF: seg_o = 7'b0001110;
      default: seg_o = 7'h7F;
    endcase
  end

endmodule

// File: rtl/hex_scan_ctrl.sv
// hex_scan_ctrl
// Time-multiplexed scan controller for a common-anode 7-segment display.
// One shared decoder is stepped across DIGITS positions, each lit for DIV
// clocks and followed by GAP_CYC all-dark clocks. New words arrive through
// a valid/ready handshake and are only applied at frame boundaries.
//   clk_i, rst_i : clock, synchronous active-high reset
//   en_i         : scan enable, 0 = display dark
//   data_i, dp_i : display word (nibble k -> digit k) and decimal points
//   valid_i      : data_i/dp_i valid
//   ready_o      : pending slot free
//   seg_o, dp_o  : active-low segments {g,f,e,d,c,b,a} and decimal point
//   an_o         : active-low anode enables
module hex_scan_ctrl
  import hex_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int DIV      = 50000,
  parameter int GAP_CYC  = 16,
  parameter int BLANK_LZ = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  en_i,
  input  logic [4*DIGITS-1:0]   data_i,
  input  logic [DIGITS-1:0]     dp_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  output logic [6:0]            seg_o,
  output logic                  dp_o,
  output logic [DIGITS-1:0]     an_o
);

  localparam int CNT_MAX = (DIV > GAP_CYC) ? DIV : GAP_CYC;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int IW      = $clog2(DIGITS);

  localparam logic [CW-1:0]     LIT_LAST = CW'(DIV - 1);
  localparam logic [CW-1:0]     GAP_LAST = CW'(GAP_CYC - 1);
  localparam logic [IW-1:0]     IDX_LAST = IW'(DIGITS - 1);
  localparam logic [DIGITS-1:0] AN_OFF   = DIGITS'(an_off(DIGITS));

  scan_state_e           state, state_n;
  logic [CW-1:0]         cnt, cnt_n;
  logic [IW-1:0]         idx, idx_n;
  logic                  frame_wrap;

  logic [4*DIGITS-1:0]   active_word, pend_word;
  logic [DIGITS-1:0]     active_dp, pend_dp;
  logic                  pend_v;

  logic [3:0]            nibble;
  logic [6:0]            hex_seg;
  logic                  lz_blank;

  assign ready_o = !pend_v;

  // Scan state, prescaler and digit index registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      idx   <= idx_n;
    end
  end

  // Next-state logic. Dropping en_i forces IDLE from anywhere, so the
  // scan always restarts at digit 0 with a full slot. frame_wrap marks the
  // GAP->LIT step that wraps the index, which is the only safe moment to
  // swap in a new word without tearing.
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    idx_n      = idx;
    frame_wrap = 1'b0;
    if (!en_i) begin
      state_n = IDLE;
      cnt_n   = '0;
      idx_n   = '0;
    end else begin
      case (state)
        IDLE: begin
          state_n = LIT;
          cnt_n   = '0;
          idx_n   = '0;
        end
        LIT: begin
          if (cnt == LIT_LAST) begin
            state_n = GAP;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        GAP: begin
          if (cnt == GAP_LAST) begin
            state_n = LIT;
            cnt_n   = '0;
            if (idx == IDX_LAST) begin
              idx_n      = '0;
              frame_wrap = 1'b1;
            end else begin
              idx_n = idx + 1'b1;
            end
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // Pending/active word registers. A held word moves to active either at a
  // frame boundary or straight away while dark. The accept and apply paths
  // cannot fire together because ready_o is low whenever pend_v is set.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      active_word <= '0;
      active_dp   <= '0;
      pend_word   <= '0;
      pend_dp     <= '0;
      pend_v      <= 1'b0;
    end else begin
      if (pend_v && (frame_wrap || state == IDLE)) begin
        active_word <= pend_word;
        active_dp   <= pend_dp;
        pend_v      <= 1'b0;
      end
      if (valid_i && !pend_v) begin
        pend_word <= data_i;
        pend_dp   <= dp_i;
        pend_v    <= 1'b1;
      end
    end
  end

  assign nibble = active_word[idx*4 +: 4];

  hex u_hex (
    .hex_i (nibble),
    .seg_o (hex_seg)
  );

  // Leading-zero blanking: digit idx>0 goes blank when it and every more
  // significant nibble are zero. Digit 0 always shows, so a zero word
  // still reads "0".
  always_comb begin
    lz_blank = 1'b0;
    if (BLANK_LZ != 0 && idx != '0) begin
      lz_blank = 1'b1;
      for (int k = 0; k < DIGITS; k++) begin
        if (k >= int'(idx) && active_word[k*4 +: 4] != 4'h0) lz_blank = 1'b0;
      end
    end
  end

  // Pin registers. Anodes, segments and dp load together so they can never
  // disagree. en_i is looked at directly so the display goes dark on the
  // first edge after enable drops rather than one slot later.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      an_o  <= AN_OFF;
      seg_o <= SEG_BLANK;
      dp_o  <= 1'b1;
    end else if (en_i && state == LIT) begin
      an_o  <= ~(DIGITS'(1) << idx);
      seg_o <= lz_blank ? SEG_BLANK : hex_seg;
      dp_o  <= ~active_dp[idx];
    end else begin
      an_o  <= AN_OFF;
      seg_o <= SEG_BLANK;
      dp_o  <= 1'b1;
    end
  end

endmodule

// File: doc/hex_scan_ctrl.md
# hex_scan_ctrl

Time-multiplexed scan controller for a common-anode multi-digit 7-segment display. It owns a single shared `hex` nibble decoder and steps it across `DIGITS` digit positions with a programmable slot time and an anti-ghosting blank gap. It accepts new display words through a valid/ready handshake and applies them only at frame boundaries, so the display never shows a mix of old and new digits. It sits between the register/status logic and the board's segment and anode pins.

## Interface
- `DIGITS`, 4: number of digit positions (2..8).
- `DIV`, 50000: clocks each digit is lit per slot (≥2).
- `GAP_CYC`, 16: all-anodes-off clocks between slots (≥1).
- `BLANK_LZ`, 1: 1 = blank leading zeros; 0 = show all digits.

Ports:
- `clk_i`  in  1  single clock; all logic is on the rising edge.
- `rst_i`  in  1  synchronous, active-high reset.
- `en_i`  in  1  scan enable; 0 = display dark.
- `data_i`  in  4*DIGITS  display word; nibble k drives digit k, digit 0 is least significant.
- `dp_i`  in  DIGITS  decimal-point request per digit, active-high; sampled with `data_i`.
- `valid_i`  in  1  `data_i`/`dp_i` valid.
- `ready_o`  out  1  pending slot free; transfer happens when `valid_i` && `ready_o`.
- `seg_o`  out  7  segments, active-low, bit order {g,f,e,d,c,b,a}.
- `dp_o`  out  1  decimal point, active-low.
- `an_o`  out  DIGITS  anode enables, active-low, one-hot-low when lit.

## Operation
- Registers:
  - `active` word + dp: what is displayed.
  - `pending` word + dp, plus a `pend_v` flag.
  - Digit index `idx`, 0..DIGITS-1.
  - Prescaler `cnt`, 0..max(DIV,GAP_CYC)-1.
- States:
  - IDLE: `en_i`=0; all outputs dark.
  - LIT: `an_o[idx]`=0; segments show digit `idx`.
  - GAP: all outputs dark.
- Transitions:
  - IDLE→LIT when `en_i`=1, with `idx`=0 and `cnt`=0.
  - LIT→GAP when `cnt`=DIV-1.
  - GAP→LIT when `cnt`=GAP_CYC-1. `idx` increments on this transition and wraps DIGITS-1→0.
  - Any state→IDLE when `en_i`=0. This clears `idx` and `cnt`.
- Frame boundary: the GAP→LIT transition where `idx` wraps to 0. If `pend_v`=1 there, `active`←`pending` and `pend_v`←0.
- In IDLE, a set `pend_v` is copied to `active` immediately on the next clock, since the display is dark.
- Handshake:
  - `ready_o` = !`pend_v`.
  - An accepted transfer sets `pend_v` and captures `data_i`/`dp_i`.
  - Once `pend_v` is set, `valid_i` is ignored until it clears.
- Simultaneous events:
  - A transfer accepted in the same cycle as a frame-boundary apply goes into `pending` and waits for the next boundary.
  - `rst_i` overrides everything.
- Leading-zero blanking (`BLANK_LZ`=1):
  - Digit k>0 is blanked (`seg_o`=7'h7F) when nibbles k..DIGITS-1 of `active` are all zero.
  - Digit 0 is never blanked.
  - `dp_o` follows `dp` even on a blanked digit.
- Decode: the nibble selected by `idx` goes through the shared `hex` decoder (0–F, active-low patterns).

## Timing
- All outputs are registered. `an_o`, `seg_o` and `dp_o` change on the same edge, one clock after the state/`idx` update. They are never misaligned.
- Period per digit: DIV lit + GAP_CYC dark clocks.
- Frame period: DIGITS*(DIV+GAP_CYC).
- Reset values:
  - Outputs: `an_o`=all 1, `seg_o`=7'h7F, `dp_o`=1, `ready_o`=1.
  - Internal: state IDLE, `idx`=0, `cnt`=0, `active`=0, `dp`=0, `pend_v`=0.
- Reset or `en_i` falling mid-slot: outputs go dark on the following edge. There is no partial gap.
- Latency from an accepted transfer to visible change: up to one frame plus 1 clock. From IDLE it is 2 clocks after `en_i` rises.

## Structure
- Package `hex_pkg`:
  - `SEG_BLANK` = 7'h7F.
  - State enum {IDLE, LIT, GAP}.
  - Anode-off constant helper.
- Sub-module: one instance of the existing `hex` decoder, fed the muxed nibble. Its output is blank-gated and then registered here.
- Target size is about 150–200 lines.

## Test plan
All scenarios use DIGITS=4, DIV=4, GAP_CYC=1.
- Reset: hold `rst_i` for 3 clocks → `an_o`=4'b1111, `seg_o`=7'h7F, `dp_o`=1, `ready_o`=1.
- Enable with `data_i`=16'h12AF loaded:
  - Anodes step through 1110,1101,1011,0111.
  - Each digit is lit 4 clocks, followed by a 1-clock 1111 gap.
  - `seg_o` per digit is 0001110 (F), 0001000 (A), 0100100 (2), 1111001 (1).
- Blanking with `data_i`=16'h0007 and `BLANK_LZ`=1: digits 3..1 show `seg_o`=7'h7F with their anode low; digit 0 shows 1111000.
- Tear-free update:
  - Load 16'h1111, then load 16'h2222 during digit 2.
  - `ready_o` stays 0 until the boundary.
  - Digit 3 still shows 1, and the next frame is all 2.
- Back-to-back loads: hold `valid_i`=1 with two words → the second is accepted only after `ready_o` returns to 1 at the frame boundary.
- `en_i` dropped mid-slot on digit 2 → dark on the next clock. On re-enable, the scan restarts at digit 0 with a full 4-clock slot.
